dac_chirp_sched: RTL and testbench
==================================

DAC_CHIRP_SCHED -- requirements
Module: dac_chirp_sched

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: DAC sample width; width of the step field.
REQ-002 SHALL have parameter LWIDTH, default 16: width of a segment length, counted in frames.
REQ-003 SHALL have parameter NSEG, default 4: number of segment table entries; must be a power of 2.
REQ-004 SHALL have parameter DIV, default 10: frame period in clk10m cycles; minimum DWIDTH+2.
REQ-005 Ports (one clock; reset is asynchronous and active-high):
- clk10m  in  1  system/device clock.
- rst  in  1  asynchronous active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  log2(NSEG)  table entry index.
- cfg_opmode  in  2  waveform mode: 00 triangle, 01 sawtooth, 10 square, 11 pulse.
- cfg_step  in  DWIDTH  step size.
- cfg_len  in  LWIDTH  segment length in frames; 0 disables the entry.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- start  in  1  begin a sweep.
- stop  in  1  abort the sweep.
- loop  in  1  repeat the table.
- busy  out  1  high in ARM and RUN.
- done  out  1  one-cycle pulse when a sweep ends.
- opmode  out  2  to the DAC interface.
- stepsize  out  DWIDTH  to the DAC interface.
- dce_n  out  1  frame latch strobe.
- chirp_n  out  1  low for the first frame of each segment.
- seg_idx  out  log2(NSEG)  active entry index.

Function
REQ-006 SHALL run frame counter fcnt from 0 to DIV-1 and wrap to 0; it is free-running from reset. frame_tick = (fcnt==DIV-1).
REQ-007 SHALL drive dce_n as a registered output that is low for exactly one cycle per frame, aligned with frame_tick; high otherwise.
REQ-008 SHALL implement FSM states IDLE, ARM and RUN.
REQ-009 IDLE: start=1 and stop=0 -> ARM. start is ignored in ARM and RUN.
REQ-010 ARM, at frame_tick, when at least one entry is enabled:
- load the lowest-index enabled entry;
- go to RUN;
- set remaining = len-1.
REQ-011 ARM, at frame_tick, when no entry is enabled: pulse done and go to IDLE.
REQ-012 RUN, at frame_tick with remaining!=0: decrement remaining.
REQ-013 RUN, at frame_tick with remaining==0, when a higher-index enabled entry exists: load it.
REQ-014 RUN, at frame_tick with remaining==0, when no higher-index enabled entry exists:
- loop=1: reload the lowest-index enabled entry;
- loop=0: pulse done and go to IDLE.
REQ-015 opmode, stepsize and seg_idx SHALL change only on the frame_tick edge on which an entry is loaded, so the DAC always latches a coherent pair.
REQ-016 chirp_n SHALL go low on each load edge, including loop reloads, and return high on the next frame_tick edge (one full frame, DIV cycles).
REQ-017 stop=1 in ARM or RUN is registered; at the next frame_tick the block SHALL pulse done and go to IDLE. opmode and stepsize hold their values.
REQ-018 stop and start asserted in the same cycle: stop wins; the block stays in or returns to IDLE.
REQ-019 cfg_we in IDLE SHALL write the entry in one cycle. cfg_we while busy SHALL leave the table unchanged and pulse cfg_err.
REQ-020 done and chirp_n SHALL never be active in the same cycle as a rejected write's side effects; outputs are registered and have no combinational path from inputs.

Reset
REQ-021 rst SHALL asynchronously force:
- state IDLE, fcnt 0;
- all table entries: len 0, step 0, opmode 00;
- opmode 00, stepsize 0, seg_idx 0;
- dce_n 1, chirp_n 1;
- busy 0, done 0, cfg_err 0.
REQ-022 Reset mid-sweep SHALL abort without a done pulse; after rst falls, start is required to run again.

Structure
REQ-023 Opmode encodings, FSM state encodings and DIV/LWIDTH defaults SHALL live in shared package dac_pkg.
REQ-024 Frame counter and dce_n generation SHALL be sub-module dac_frame_timer, with ports clk10m, rst and outputs frame_tick, dce_n. The FSM and table stay in the top module.

Verification (DIV=10, DWIDTH=8)
REQ-025 Idle after reset -> dce_n low for 1 cycle every 10 cycles; chirp_n=1, busy=0.
REQ-026 Entries 0:{01,step 4,len 3} and 2:{00,step 9,len 2}, start, loop=0 -> stepsize 4 for 30 cycles, then 9 for 20 cycles; seg_idx 0 then 2; chirp_n low 10 cycles at each load; done pulse; busy=0.
REQ-027 Same table with loop=1 -> sequence 0,2,0,2...; stop during the second segment -> done at the next frame_tick, stepsize held at 9.
REQ-028 All entries len 0, start -> done at the first frame_tick; chirp_n stays 1.
REQ-029 cfg_we to entry 1 while busy -> cfg_err pulse; entry 1 unchanged when read back through the next sweep.
REQ-030 rst asserted mid-RUN -> all outputs immediately at reset values; no done pulse; start together with stop -> stays IDLE.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared encodings and default timing for the DAC chirp scheduler.
package dac_pkg;

  localparam int DIV_DEF    = 10;
  localparam int LWIDTH_DEF = 16;

  typedef enum logic [1:0] {
    OP_TRI   = 2'b00,
    OP_SAW   = 2'b01,
    OP_SQR   = 2'b10,
    OP_PULSE = 2'b11
  } opmode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/dac_frame_timer.sv
// Free-running frame counter; dce_n is registered so its low cycle lines up with frame_tick.
module dac_frame_timer
  import dac_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clk10m,
  input  logic rst,
  output logic frame_tick,
  output logic dce_n
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] fcnt;

  assign frame_tick = (fcnt == CW'(DIV - 1));

  always_ff @(posedge clk10m or posedge rst) begin
    if (rst) begin
      fcnt  <= '0;
      dce_n <= 1'b1;
    end else begin
      fcnt  <= frame_tick ? '0 : fcnt + CW'(1);
      dce_n <= (fcnt != CW'(DIV - 2));
    end
  end

endmodule

// File: rtl/dac_chirp_sched.sv
// Segment-table chirp scheduler: walks enabled table entries frame by frame and
// presents a coherent opmode/stepsize pair to the DAC on each load edge.
//   state | meaning
//   IDLE  | table writable, waiting for start
//   ARM   | sweep requested, waiting for the first frame boundary
//   RUN   | counting frames of the active segment
module dac_chirp_sched
  import dac_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int LWIDTH = LWIDTH_DEF,
  parameter int NSEG   = 4,
  parameter int DIV    = DIV_DEF
) (
  input  logic                    clk10m,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [$clog2(NSEG)-1:0] cfg_addr,
  input  logic [1:0]              cfg_opmode,
  input  logic [DWIDTH-1:0]       cfg_step,
  input  logic [LWIDTH-1:0]       cfg_len,
  output logic                    cfg_err,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              opmode,
  output logic [DWIDTH-1:0]       stepsize,
  output logic                    dce_n,
  output logic                    chirp_n,
  output logic [$clog2(NSEG)-1:0] seg_idx
);

  localparam int AW = $clog2(NSEG);

  state_t              state, state_nx;
  logic                frame_tick;
  logic                stop_pend;
  logic [LWIDTH-1:0]   remaining;

  opmode_t             tbl_op   [NSEG];
  logic [DWIDTH-1:0]   tbl_step [NSEG];
  logic [LWIDTH-1:0]   tbl_len  [NSEG];

  logic                first_vld, next_vld;
  logic [AW-1:0]       first_idx, next_idx;
  logic                load, finish;
  logic [AW-1:0]       load_idx;

  dac_frame_timer #(.DIV(DIV)) u_timer (
    .clk10m     (clk10m),
    .rst        (rst),
    .frame_tick (frame_tick),
    .dce_n      (dce_n)
  );

  // Priority search, scanning downward so the lowest matching index wins.
  always_comb begin
    first_vld = 1'b0;
    first_idx = '0;
    next_vld  = 1'b0;
    next_idx  = '0;
    for (int i = NSEG - 1; i >= 0; i--) begin
      if (tbl_len[i] != '0) begin
        first_vld = 1'b1;
        first_idx = AW'(i);
        if (i > int'(seg_idx)) begin
          next_vld = 1'b1;
          next_idx = AW'(i);
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_idx = first_idx;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) state_nx = ST_ARM;
      end
      ST_ARM: begin
        if (frame_tick) begin
          if (stop_pend || !first_vld) begin
            finish   = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            load     = 1'b1;
            state_nx = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (frame_tick) begin
          if (stop_pend) begin
            finish   = 1'b1;
            state_nx = ST_IDLE;
          end else if (remaining == '0) begin
            if (next_vld) begin
              load     = 1'b1;
              load_idx = next_idx;
            end else if (loop && first_vld) begin
              load = 1'b1;
            end else begin
              finish   = 1'b1;
              state_nx = ST_IDLE;
            end
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk10m or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      stop_pend <= 1'b0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      opmode    <= OP_TRI;
      stepsize  <= '0;
      seg_idx   <= '0;
      chirp_n   <= 1'b1;
      for (int i = 0; i < NSEG; i++) begin
        tbl_op[i]   <= OP_TRI;
        tbl_step[i] <= '0;
        tbl_len[i]  <= '0;
      end
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != ST_IDLE);
      done      <= finish;
      cfg_err   <= cfg_we && (state != ST_IDLE);
      // A pending stop is dropped once the FSM is back in IDLE.
      stop_pend <= (state_nx != ST_IDLE) && (stop_pend || (stop && state != ST_IDLE));

      if (load) begin
        remaining <= tbl_len[load_idx] - LWIDTH'(1);
        seg_idx   <= load_idx;
        opmode    <= tbl_op[load_idx];
        stepsize  <= tbl_step[load_idx];
        chirp_n   <= 1'b0;
      end else begin
        if (state == ST_RUN && frame_tick && remaining != '0)
          remaining <= remaining - LWIDTH'(1);
        if (frame_tick)
          chirp_n <= 1'b1;
      end

      if (cfg_we && state == ST_IDLE) begin
        tbl_op[cfg_addr]   <= opmode_t'(cfg_opmode);
        tbl_step[cfg_addr] <= cfg_step;
        tbl_len[cfg_addr]  <= cfg_len;
      end
    end
  end

endmodule

// File: tb/tb_dac_chirp_sched.sv
// Directed bench for dac_chirp_sched: expected load/done events are queued when a
// sweep is launched and matched by a monitor as the DUT produces them.
module tb_dac_chirp_sched;

  localparam int DIV    = 10;
  localparam int K_LOAD = 1;
  localparam int K_DONE = 2;

  logic        clk10m = 1'b0;
  logic        rst    = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [1:0]  cfg_opmode = '0;
  logic [7:0]  cfg_step = '0;
  logic [15:0] cfg_len = '0;
  logic        cfg_err;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic        busy, done, dce_n, chirp_n;
  logic [1:0]  opmode;
  logic [7:0]  stepsize;
  logic [1:0]  seg_idx;

  dac_chirp_sched dut (
    .clk10m     (clk10m),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_opmode (cfg_opmode),
    .cfg_step   (cfg_step),
    .cfg_len    (cfg_len),
    .cfg_err    (cfg_err),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .busy       (busy),
    .done       (done),
    .opmode     (opmode),
    .stepsize   (stepsize),
    .dce_n      (dce_n),
    .chirp_n    (chirp_n),
    .seg_idx    (seg_idx)
  );

  always #5 clk10m = ~clk10m;

  typedef struct {
    int kind;
    int seg;
    int step;
    int op;
    int gap;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   evt_cnt = 0;
  int   cyc     = 0;
  int   last_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_load(input int seg, input int step, input int op, input int gap);
    exp_t e;
    e.kind = K_LOAD; e.seg = seg; e.step = step; e.op = op; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic push_done(input int gap);
    exp_t e;
    e.kind = K_DONE; e.seg = 0; e.step = 0; e.op = 0; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic handle_event(input int kind);
    exp_t e;
    evt_cnt++;
    chk("event_expected", (q.size() != 0), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == K_LOAD) begin
        chk("load_seg_idx", seg_idx, e.seg);
        chk("load_stepsize", stepsize, e.step);
        chk("load_opmode", opmode, e.op);
      end
      if (e.gap >= 0) chk("event_gap", cyc - last_cyc, e.gap);
    end
    last_cyc = cyc;
  endtask

  // Monitor: chirp_n falling edge is a load, done high is a sweep end.
  initial begin
    logic prev_chirp;
    int   low_cnt;
    prev_chirp = 1'b1;
    low_cnt    = 0;
    forever begin
      @(negedge clk10m);
      cyc++;
      if (rst) begin
        prev_chirp = 1'b1;
        low_cnt    = 0;
      end else begin
        if (!chirp_n) low_cnt++;
        if (prev_chirp && !chirp_n) handle_event(K_LOAD);
        if (!prev_chirp && chirp_n) begin
          chk("chirp_low_len", low_cnt, DIV);
          low_cnt = 0;
        end
        if (done) handle_event(K_DONE);
        prev_chirp = chirp_n;
      end
    end
  end

  task automatic cfg_write(input int a, input int op, input int st, input int ln);
    @(negedge clk10m);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_opmode = 2'(op);
    cfg_step = 8'(st); cfg_len = 16'(ln);
    @(negedge clk10m);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk10m);
    start = 1'b1;
    @(negedge clk10m);
    start = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk10m);
      budget--;
    end
    chk(tag, q.size(), 0);
    @(negedge clk10m);
  endtask

  task automatic wait_evts(input int n, input int budget);
    while (evt_cnt < n && budget > 0) begin
      @(negedge clk10m);
      budget--;
    end
    chk("wait_events", (evt_cnt >= n), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_opmode"}, opmode, 0);
    chk({tag, "_stepsize"}, stepsize, 0);
    chk({tag, "_seg_idx"}, seg_idx, 0);
    chk({tag, "_dce_n"}, dce_n, 1);
    chk({tag, "_chirp_n"}, chirp_n, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  task automatic sweep_once(input string tag);
    push_load(0, 4, 1, -1);
    push_load(2, 9, 0, 30);
    push_done(20);
    loop = 1'b0;
    pulse_start();
    drain({tag, "_drain"}, 120);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_done_end"}, done, 0);
    chk({tag, "_step_held"}, stepsize, 9);
    chk({tag, "_seg_held"}, seg_idx, 2);
  endtask

  initial begin
    int n_low, last_low, bad_flags, busy_seen, base;

    // Reset state
    #12;
    chk_reset_outputs("rst");
    @(negedge clk10m);
    rst = 1'b0;

    // Idle framing: one dce_n low cycle every DIV cycles
    n_low = 0; last_low = -1; bad_flags = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk10m);
      if (!dce_n) begin
        if (last_low >= 0) chk("dce_period", i - last_low, DIV);
        last_low = i;
        n_low++;
      end
      if (!chirp_n || busy) bad_flags++;
    end
    chk("dce_lows_in_50", n_low, 5);
    chk("idle_chirp_busy", bad_flags, 0);

    // Two-entry sweep, no loop
    cfg_write(0, 1, 4, 3);
    cfg_write(2, 0, 9, 2);
    sweep_once("sweep1");

    // Looping sweep with a rejected write and a stop in the second segment
    push_load(0, 4, 1, -1);
    push_load(2, 9, 0, 30);
    push_load(0, 4, 1, 20);
    push_load(2, 9, 0, 30);
    push_done(10);
    base = evt_cnt;
    loop = 1'b1;
    pulse_start();
    chk("loop_busy_arm", busy, 1);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_opmode = 2'd3; cfg_step = 8'd77; cfg_len = 16'd1;
    @(negedge clk10m);
    chk("cfg_err_pulse", cfg_err, 1);
    cfg_we = 1'b0;
    @(negedge clk10m);
    chk("cfg_err_clear", cfg_err, 0);
    wait_evts(base + 4, 150);
    repeat (3) @(negedge clk10m);
    stop = 1'b1;
    @(negedge clk10m);
    stop = 1'b0;
    drain("loop_stop_drain", 40);
    chk("stop_step_held", stepsize, 9);
    chk("stop_seg_held", seg_idx, 2);
    chk("stop_busy", busy, 0);
    loop = 1'b0;

    // Entry 1 must still be disabled
    sweep_once("sweep2");

    // Empty table: done at the first frame boundary, no load
    cfg_write(0, 1, 4, 0);
    cfg_write(2, 0, 9, 0);
    push_done(-1);
    pulse_start();
    drain("empty_drain", 15);
    chk("empty_busy", busy, 0);
    chk("empty_chirp", chirp_n, 1);

    // Reset mid-RUN
    cfg_write(0, 1, 4, 3);
    cfg_write(2, 0, 9, 2);
    push_load(0, 4, 1, -1);
    base = evt_cnt;
    loop = 1'b1;
    pulse_start();
    wait_evts(base + 1, 30);
    repeat (5) @(negedge clk10m);
    chk("prerst_busy", busy, 1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    q.delete();
    repeat (3) @(negedge clk10m);
    rst = 1'b0;
    loop = 1'b0;
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk10m);
      if (busy || done) busy_seen++;
    end
    chk("postrst_idle", busy_seen, 0);

    // start together with stop stays in IDLE
    @(negedge clk10m);
    start = 1'b1; stop = 1'b1;
    @(negedge clk10m);
    start = 1'b0; stop = 1'b0;
    busy_seen = 0;
    repeat (25) begin
      @(negedge clk10m);
      if (busy || done) busy_seen++;
    end
    chk("start_stop_idle", busy_seen, 0);

    // Reset cleared the table, so a new sweep ends without loading
    push_done(-1);
    pulse_start();
    drain("postrst_sweep_drain", 15);
    chk("postrst_stepsize", stepsize, 0);
    chk("postrst_chirp", chirp_n, 1);

    repeat (5) @(negedge clk10m);
    chk("queue_empty_end", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
